rx232_rx_fifo: RTL
==================

Name: rx232_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART bit-level receiver.
- Consumes the receiver's parallel byte (rxpd) and its frame strobes (rx_start, rxen).
- Detects each completed frame and pushes the byte into a DEPTH-entry FIFO.
- Presents the FIFO to the host/command logic through a simple read-enable interface, with fill level and sticky overflow status.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, pointer width = log2(DEPTH).
- DW, 8, data width; fixed to the UART byte width.

Ports:
- clk  in  1  system clock, same clock as the receiver.
- rst  in  1  synchronous, active-high reset.
- rxpd  in  8  received byte from receiver; stable from one bit period before rx_start rises until the next frame completes.
- rx_start  in  1  receiver frame-complete strobe; high for 3 bit periods after each completed frame.
- rxen  in  1  receiver activity level; high for 10 bit periods after a frame.
- rd_en  in  1  host pop request; one byte per clk cycle.
- rd_data  out  8  popped byte, registered.
- rd_valid  out  1  one-cycle pulse; rd_data holds a newly popped byte.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a frame arrived while full and was dropped.
- ovf_clr  in  1  clears overflow and drop_cnt.
- drop_cnt  out  8  number of dropped frames, saturates at 255.
- rx_active  out  1  rxen registered by one clk; status only.

Behaviour:
- All flops update on posedge clk only. rst is synchronous and active-high, and overrides every other input.
- Reset values:
  - rd_data = 8'h00, rd_valid = 0, empty = 1, full = 0, count = 0.
  - overflow = 0, drop_cnt = 0, rx_active = 0.
  - Read and write pointers = 0.
  - rx_start_d = 1.
- Push strobe: push = rx_start & ~rx_start_d, where rx_start_d is rx_start registered once.
  - rx_start_d resets to 1, so if rx_start is high when reset is released, no push occurs until rx_start goes low and then rises again.
  - Back-to-back frames keep rxen high continuously, but rx_start still toggles once per frame. rxen is therefore never used as the push strobe.
- Write: on push with full = 0 (or full = 1 with an accepted pop in the same cycle), mem[wptr] <= rxpd and wptr wraps modulo DEPTH.
- Read: on rd_en with empty = 0, rd_data <= mem[rptr], rptr wraps, and rd_valid = 1 in the following cycle.
  - rd_en while empty is ignored: rd_valid = 0 and rd_data holds.
- Pop-to-data latency is 1 cycle. Push-to-empty-deassert latency is 1 cycle after the push cycle.
- count update per cycle:
  - +1 on an accepted push only.
  - −1 on an accepted pop only.
  - Unchanged on both or neither.
  - full = (count == DEPTH); empty = (count == 0). Both are registered, consistent with count.
- Simultaneous push and pop:
  - When empty: the pop is rejected, the push is accepted, and count becomes 1.
  - When full: both are accepted, count stays DEPTH, and no overflow occurs.
  - Otherwise: both are accepted and count is unchanged.
- Overflow: a push with full = 1 and no accepted pop drops the byte.
  - overflow <= 1, and drop_cnt increments, saturating at 8'hFF.
  - FIFO contents and pointers are unchanged.
- ovf_clr clears overflow and drop_cnt. If a drop occurs in the same cycle, the set wins: overflow = 1 and drop_cnt = 1.
- Pointers use AW+1 bits with wrap. count is derived consistently and never exceeds DEPTH.
- Reset mid-operation discards all contents. A frame completing on the reset cycle is lost.

Decomposition:
- Package rx232_pkg: DW = 8, DEFAULT_DEPTH = 16, DROP_CNT_W = 8, and a clog2 helper constant function.
- One sub-module, rx232_fifo_mem: a DEPTH×DW storage array with a synchronous write port and a registered read port, no reset on the array.
- Edge detection, pointers, count and status logic stay in the top module.

Test Plan:
- Single frame, rxpd = 8'hA5, rx_start pulse of 3 bit periods -> exactly one push, count = 1, empty = 0. rd_en for 1 cycle -> rd_valid next cycle with rd_data = 8'hA5, then empty = 1.
- 10 back-to-back frames 8'h00..8'h09 with rxen held high throughout -> count = 10. Ten reads return 00..09 in order with no duplicates.
- 17 frames with DEPTH = 16 and no reads -> full = 1 after the 16th frame, 17th byte dropped, overflow = 1, drop_cnt = 1. Reads return the first 16 bytes.
- Full FIFO, push and rd_en in the same cycle -> count stays 16, overflow stays 0. The oldest byte is returned and the new byte is stored last.
- Overflow set, ovf_clr asserted in the same cycle as another drop -> overflow = 1, drop_cnt = 1. ovf_clr alone on the next cycle -> overflow = 0, drop_cnt = 0.
- rst asserted while rx_start is high and count = 5 -> count = 0, empty = 1. No push until rx_start falls and rises again.

Source files
------------

// File: rtl/rx232_pkg.sv
// Shared constants and helpers for the UART receive-side byte buffer.
package rx232_pkg;

    localparam int DW            = 8;   // UART byte width
    localparam int DEFAULT_DEPTH = 16;  // default FIFO depth in bytes
    localparam int DROP_CNT_W    = 8;   // width of the saturating drop counter

    // Ceiling log2 for sizing pointers from a depth; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : rx232_pkg

// File: rtl/rx232_fifo_mem.sv
// DEPTH x DW byte store with a synchronous write port and a registered read port.
module rx232_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage write; read and write to the same slot return the old byte.
    // NOTE: the array has no reset -- stale entries are never observable
    // because the pointers gate every read, and a reset here would cost a
    // mux per bit for no functional benefit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when no pop is accepted.
    // NOTE: non-blocking assignment on every flop so all registers sample
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : rx232_fifo_mem

// File: rtl/rx232_rx_fifo.sv
// Receive byte buffer: detects completed UART frames on the rising edge of
// rx_start, queues the byte, and offers it to the host through rd_en.
module rx232_rx_fifo
    import rx232_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         rxpd,
    input  logic                  rx_start,
    input  logic                  rxen,
    input  logic                  rd_en,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [AW:0]           count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  rx_active
);

    logic                  rx_start_q;
    logic [AW:0]           wptr_q,   wptr_d;
    logic [AW:0]           rptr_q,   rptr_d;
    logic [AW:0]           count_q,  count_d;
    logic                  empty_q,  empty_d;
    logic                  full_q,   full_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  rd_valid_q;
    logic                  rx_active_q;

    logic push;
    logic pop_ok;
    logic push_ok;
    logic drop;

    // Frame strobe and acceptance decisions. rxen stays high across
    // back-to-back frames, so only the rx_start edge marks a new byte.
    always_comb begin
        push    = rx_start & ~rx_start_q;
        pop_ok  = rd_en & ~empty_q;
        push_ok = push & (~full_q | pop_ok);
        drop    = push & full_q & ~pop_ok;
    end

    // Next-state for pointers, occupancy and overflow status.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_ok) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end

        // A drop in the same cycle as ovf_clr wins and restarts the count at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = DROP_CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end

        count_d = wptr_d - rptr_d;
        empty_d = (count_d == '0);
        full_d  = (count_d == (AW+1)'(DEPTH));
    end

    // State registers; rx_start_q resets high so a strobe already asserted
    // when reset releases is not mistaken for a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_start_q  <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            rd_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            rx_start_q  <= rx_start;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_valid_q  <= pop_ok;
            rx_active_q <= rxen;
        end
    end

    rx232_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wptr_q[AW-1:0]),
        .wdata (rxpd),
        .re    (pop_ok),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign rx_active = rx_active_q;

endmodule : rx232_rx_fifo
